// File: rtl/demux_reg_bank.sv
// Demultiplexing register bank: single-word writes are steered into WIDTH lanes
// (addressed by sel or by an auto-incrementing pointer) and released as one frame.
module demux_reg_bank #(
    parameter int WIDTH   = 16,
    parameter int BITSIZE = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [BITSIZE-1:0]       din,
    input  logic [$clog2(WIDTH)-1:0] sel,
    input  logic                     addr_mode,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic                     out_ready,
    output logic [BITSIZE*WIDTH-1:0] y,
    output logic [WIDTH-1:0]         lane_vld,
    output logic                     out_valid,
    output logic [$clog2(WIDTH)-1:0] ptr,
    output logic                     sel_err
);

    localparam int SW = $clog2(WIDTH);

    typedef enum logic {
        FILL = 1'b0,
        HOLD = 1'b1
    } state_t;

    state_t               state_reg;
    logic                 out_valid_reg;
    logic [WIDTH-1:0]     lane_vld_reg;
    logic [SW-1:0]        ptr_reg;
    logic                 sel_err_reg;

    logic                 accept;
    logic [SW-1:0]        target;
    logic                 in_range;
    logic [SW-1:0]        ptr_inc;
    logic [WIDTH-1:0]     lane_we;
    logic [WIDTH-1:0]     lane_vld_set;
    logic [BITSIZE-1:0]   lane_reg [WIDTH];

    // in_ready is gated by rst_n so nothing is offered while reset is held
    assign in_ready = rst_n && (state_reg == FILL);
    assign accept   = in_valid && in_ready;
    assign target   = addr_mode ? ptr_reg : sel;
    assign in_range = (int'(target) < WIDTH);
    assign ptr_inc  = (ptr_reg == SW'(WIDTH - 1)) ? '0 : ptr_reg + 1'b1;

    assign lane_vld_set = lane_vld_reg | lane_we;

    generate
        for (genvar gi = 0; gi < WIDTH; gi++) begin : g_lane
            assign lane_we[gi] = accept && in_range && (target == SW'(gi));

            // Lane data survives frame release; only reset clears it
            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    lane_reg[gi] <= '0;
                end else if (lane_we[gi]) begin
                    lane_reg[gi] <= din;
                end
            end

            assign y[gi*BITSIZE +: BITSIZE] = lane_reg[gi];
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg     <= FILL;
            out_valid_reg <= 1'b0;
            lane_vld_reg  <= '0;
            ptr_reg       <= '0;
            sel_err_reg   <= 1'b0;
        end else begin
            case (state_reg)
                FILL: begin
                    if (accept) begin
                        if (in_range) begin
                            lane_vld_reg <= lane_vld_set;
                            if (addr_mode) begin
                                ptr_reg <= ptr_inc;
                            end
                            if (&lane_vld_set) begin
                                state_reg     <= HOLD;
                                out_valid_reg <= 1'b1;
                            end
                        end else begin
                            sel_err_reg <= 1'b1;
                        end
                    end
                end
                HOLD: begin
                    if (out_ready) begin
                        state_reg     <= FILL;
                        out_valid_reg <= 1'b0;
                        lane_vld_reg  <= '0;
                        ptr_reg       <= '0;
                    end
                end
                default: begin
                    state_reg     <= FILL;
                    out_valid_reg <= 1'b0;
                end
            endcase
        end
    end

    assign out_valid = out_valid_reg;
    assign lane_vld  = lane_vld_reg;
    assign ptr       = ptr_reg;
    assign sel_err   = sel_err_reg;

endmodule

// File: tb/tb_demux_reg_bank.sv
// Bench for demux_reg_bank: a WIDTH=4 instance for the main behaviour and a
// WIDTH=5 instance for out-of-range addressing; frames go through a scoreboard.
module tb_demux_reg_bank;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int vectors = 0;
    int fails   = 0;

    // WIDTH=4, BITSIZE=8 instance
    logic        rst_n4, addr_mode4, in_valid4, out_ready4;
    logic [7:0]  din4;
    logic [1:0]  sel4, ptr4;
    logic        in_ready4, out_valid4, sel_err4;
    logic [31:0] y4;
    logic [3:0]  lane_vld4;

    demux_reg_bank #(.WIDTH(4), .BITSIZE(8)) dut4 (
        .clk(clk), .rst_n(rst_n4), .din(din4), .sel(sel4), .addr_mode(addr_mode4),
        .in_valid(in_valid4), .in_ready(in_ready4), .out_ready(out_ready4),
        .y(y4), .lane_vld(lane_vld4), .out_valid(out_valid4), .ptr(ptr4), .sel_err(sel_err4)
    );

    // WIDTH=5, BITSIZE=8 instance
    logic        rst_n5, addr_mode5, in_valid5, out_ready5;
    logic [7:0]  din5;
    logic [2:0]  sel5, ptr5;
    logic        in_ready5, out_valid5, sel_err5;
    logic [39:0] y5;
    logic [4:0]  lane_vld5;

    demux_reg_bank #(.WIDTH(5), .BITSIZE(8)) dut5 (
        .clk(clk), .rst_n(rst_n5), .din(din5), .sel(sel5), .addr_mode(addr_mode5),
        .in_valid(in_valid5), .in_ready(in_ready5), .out_ready(out_ready5),
        .y(y5), .lane_vld(lane_vld5), .out_valid(out_valid5), .ptr(ptr5), .sel_err(sel_err5)
    );

    logic [31:0] exp4_q [$];
    logic [39:0] exp5_q [$];
    logic        ov4_prev = 1'b0;
    logic        ov5_prev = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Frame monitor: every rising out_valid must match the oldest expected frame
    always @(negedge clk) begin
        if (out_valid4 === 1'b1 && !ov4_prev) begin
            if (exp4_q.size() == 0) begin
                vectors++;
                fails++;
                $display("FAIL frame4: unexpected frame y=0x%0h", y4);
            end else begin
                chk("frame4", {32'd0, y4}, {32'd0, exp4_q.pop_front()});
            end
        end
        if (out_valid5 === 1'b1 && !ov5_prev) begin
            if (exp5_q.size() == 0) begin
                vectors++;
                fails++;
                $display("FAIL frame5: unexpected frame y=0x%0h", y5);
            end else begin
                chk("frame5", {24'd0, y5}, {24'd0, exp5_q.pop_front()});
            end
        end
        ov4_prev = (out_valid4 === 1'b1);
        ov5_prev = (out_valid5 === 1'b1);
    end

    // One accept cycle; returns #1 after the edge so results are visible
    task automatic write4(input logic mode, input logic [1:0] s, input logic [7:0] d);
        addr_mode4 = mode;
        sel4       = s;
        din4       = d;
        in_valid4  = 1'b1;
        @(posedge clk);
        #1;
        in_valid4  = 1'b0;
        $display("dut4 write mode=%0d sel=%0d din=0x%02h -> y=0x%08h vld=%b ptr=%0d ov=%0d",
                 mode, s, d, y4, lane_vld4, ptr4, out_valid4);
    endtask

    task automatic write5(input logic mode, input logic [2:0] s, input logic [7:0] d);
        addr_mode5 = mode;
        sel5       = s;
        din5       = d;
        in_valid5  = 1'b1;
        @(posedge clk);
        #1;
        in_valid5  = 1'b0;
        $display("dut5 write mode=%0d sel=%0d din=0x%02h -> y=0x%010h vld=%b ptr=%0d err=%0d",
                 mode, s, d, y5, lane_vld5, ptr5, sel_err5);
    endtask

    task automatic release4();
        out_ready4 = 1'b1;
        @(posedge clk);
        #1;
        out_ready4 = 1'b0;
        $display("dut4 release -> ov=%0d vld=%b y=0x%08h", out_valid4, lane_vld4, y4);
    endtask

    initial begin
        rst_n4 = 1'b0; addr_mode4 = 1'b0; in_valid4 = 1'b0; out_ready4 = 1'b0; din4 = '0; sel4 = '0;
        rst_n5 = 1'b0; addr_mode5 = 1'b0; in_valid5 = 1'b0; out_ready5 = 1'b0; din5 = '0; sel5 = '0;

        // Reset held for two edges
        repeat (2) @(posedge clk);
        #1;
        chk("rst_y",        {32'd0, y4},        64'h0);
        chk("rst_lane_vld", {60'd0, lane_vld4}, 64'h0);
        chk("rst_ptr",      {62'd0, ptr4},      64'h0);
        chk("rst_out_valid",{63'd0, out_valid4},64'h0);
        chk("rst_in_ready", {63'd0, in_ready4}, 64'h0);
        rst_n4 = 1'b1;
        rst_n5 = 1'b1;
        #1;
        chk("rel_in_ready", {63'd0, in_ready4}, 64'h1);
        @(posedge clk);
        #1;

        // Auto fill, back to back
        exp4_q.push_back(32'h44332211);
        write4(1'b1, 2'd0, 8'h11);
        write4(1'b1, 2'd0, 8'h22);
        write4(1'b1, 2'd0, 8'h33);
        write4(1'b1, 2'd0, 8'h44);
        chk("auto_y",         {32'd0, y4},        64'h44332211);
        chk("auto_out_valid", {63'd0, out_valid4},64'h1);
        chk("auto_in_ready",  {63'd0, in_ready4}, 64'h0);
        chk("auto_ptr",       {62'd0, ptr4},      64'h0);

        // Backpressure in HOLD with writes offered
        din4 = 8'h99; addr_mode4 = 1'b1; in_valid4 = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            chk("bp_y",        {32'd0, y4},        64'h44332211);
            chk("bp_in_ready", {63'd0, in_ready4}, 64'h0);
            $display("dut4 hold cycle %0d y=0x%08h ov=%0d", i, y4, out_valid4);
        end
        in_valid4 = 1'b0;
        release4();
        chk("rel_out_valid", {63'd0, out_valid4}, 64'h0);
        chk("rel_lane_vld",  {60'd0, lane_vld4},  64'h0);
        chk("rel_y",         {32'd0, y4},         64'h44332211);
        chk("rel_in_ready2", {63'd0, in_ready4},  64'h1);

        // Addressed writes with overwrite; untouched lanes keep old data
        write4(1'b0, 2'd2, 8'hAA);
        write4(1'b0, 2'd2, 8'hBB);
        write4(1'b0, 2'd0, 8'h01);
        chk("addr_lane_vld",  {60'd0, lane_vld4},  64'h5);
        chk("addr_y",         {32'd0, y4},         64'h44BB2201);
        chk("addr_out_valid", {63'd0, out_valid4}, 64'h0);
        chk("addr_ptr",       {62'd0, ptr4},       64'h0);
        exp4_q.push_back(32'h66BB5501);
        write4(1'b0, 2'd1, 8'h55);
        write4(1'b0, 2'd3, 8'h66);
        chk("addr_frame_ov", {63'd0, out_valid4}, 64'h1);
        release4();

        // out_ready has no effect while filling
        write4(1'b1, 2'd0, 8'h10);
        out_ready4 = 1'b1;
        write4(1'b1, 2'd0, 8'h88);
        out_ready4 = 1'b0;
        chk("fill_oready_vld", {60'd0, lane_vld4}, 64'h3);
        chk("fill_oready_ptr", {62'd0, ptr4},      64'h2);

        // Reset mid-fill
        rst_n4 = 1'b0;
        @(posedge clk);
        #1;
        chk("midrst_y",   {32'd0, y4},        64'h0);
        chk("midrst_vld", {60'd0, lane_vld4}, 64'h0);
        chk("midrst_ptr", {62'd0, ptr4},      64'h0);
        chk("midrst_rdy", {63'd0, in_ready4}, 64'h0);
        rst_n4 = 1'b1;
        write4(1'b1, 2'd0, 8'h77);
        chk("postrst_y",   {32'd0, y4},        64'h00000077);
        chk("postrst_vld", {60'd0, lane_vld4}, 64'h1);
        chk("postrst_ptr", {62'd0, ptr4},      64'h1);

        // Out-of-range address on WIDTH=5
        write5(1'b0, 3'd6, 8'hEE);
        chk("oor_vld",  {59'd0, lane_vld5}, 64'h0);
        chk("oor_y",    {24'd0, y5},        64'h0);
        chk("oor_err",  {63'd0, sel_err5},  64'h1);
        write5(1'b0, 3'd4, 8'h12);
        write5(1'b1, 3'd0, 8'h34);
        chk("oor_vld2", {59'd0, lane_vld5}, 64'h11);
        chk("oor_ptr",  {61'd0, ptr5},      64'h1);
        chk("oor_err2", {63'd0, sel_err5},  64'h1);
        exp5_q.push_back(40'h129A785634);
        write5(1'b1, 3'd0, 8'h56);
        write5(1'b1, 3'd0, 8'h78);
        write5(1'b1, 3'd0, 8'h9A);
        chk("w5_out_valid", {63'd0, out_valid5}, 64'h1);
        chk("w5_err3",      {63'd0, sel_err5},   64'h1);

        repeat (2) @(posedge clk);
        #1;
        chk("sb4_drained", {32'd0, 32'(exp4_q.size())}, 64'h0);
        chk("sb5_drained", {32'd0, 32'(exp5_q.size())}, 64'h0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
        $finish;
    end

endmodule
